// File: rtl/ob_sorted_table.sv
// rtl/ob_sorted_table.sv - price-time sorted resting-order table, one book side; head is best price.
// Define OB_SORTED_TABLE_STATS_EN to add saturating install/reject/cancel/cancel-miss counters.
module ob_sorted_table #(
    parameter int N       = 16,
    parameter int IS_ASK  = 1,
    parameter int PRICE_W = 16,
    parameter int QTY_W   = 16,
    parameter int UID_W   = 32,
    localparam int CW     = $clog2(N + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_vld,
    output logic               cmd_rdy,
    input  logic [1:0]         cmd_op,
    input  logic [UID_W-1:0]   cmd_uid,
    input  logic [PRICE_W-1:0] cmd_price,
    input  logic [QTY_W-1:0]   cmd_qty,
    output logic               rsp_vld_r,
    output logic               rsp_ok_r,
    output logic [UID_W-1:0]   rsp_uid_r,
    output logic [PRICE_W-1:0] rsp_price_r,
    output logic [QTY_W-1:0]   rsp_qty_r,
    output logic               head_vld_r,
    output logic [UID_W-1:0]   head_uid_r,
    output logic [PRICE_W-1:0] head_price_r,
    output logic [QTY_W-1:0]   head_qty_r,
    output logic [CW-1:0]      count_r,
    output logic               reject_vld_r,
    output logic [UID_W-1:0]   reject_uid_r,
    output logic [PRICE_W-1:0] reject_price_r,
    output logic [QTY_W-1:0]   reject_qty_r,
`ifdef OB_SORTED_TABLE_STATS_EN
    output logic [31:0]        stat_install_r,
    output logic [31:0]        stat_reject_r,
    output logic [31:0]        stat_cancel_r,
    output logic [31:0]        stat_cancel_miss_r,
`endif
    input  logic               reject_pop
);

    localparam logic [1:0] OP_INSTALL = 2'd0;
    localparam logic [1:0] OP_POP     = 2'd1;
    localparam logic [1:0] OP_CANCEL  = 2'd2;
    localparam logic [1:0] OP_QTY_DEC = 2'd3;

    logic [N-1:0]       v_r, v_n;
    logic [UID_W-1:0]   uid_r   [N];
    logic [UID_W-1:0]   uid_n   [N];
    logic [PRICE_W-1:0] price_r [N];
    logic [PRICE_W-1:0] price_n [N];
    logic [QTY_W-1:0]   qty_r   [N];
    logic [QTY_W-1:0]   qty_n   [N];
    logic [CW-1:0]      count_n;

    logic               acc;
    logic [CW-1:0]      ins_pos, match_pos, rm_pos;
    logic               match_hit, rm_en, evict;
    logic [UID_W-1:0]   ev_uid;
    logic [PRICE_W-1:0] ev_price;
    logic [QTY_W-1:0]   ev_qty;
    logic               rsp_ok_n;
    logic [UID_W-1:0]   rsp_uid_n;
    logic [PRICE_W-1:0] rsp_price_n;
    logic [QTY_W-1:0]   rsp_qty_n;
    logic [QTY_W-1:0]   dec_q;

    assign cmd_rdy = ~reject_vld_r | reject_pop;
    assign acc     = cmd_vld & cmd_rdy;

    assign head_vld_r   = v_r[0];
    assign head_uid_r   = uid_r[0];
    assign head_price_r = price_r[0];
    assign head_qty_r   = qty_r[0];

    function automatic logic better(input logic [PRICE_W-1:0] a, input logic [PRICE_W-1:0] b);
        return (IS_ASK != 0) ? (a < b) : (a > b);
    endfunction

    // Downward scans leave the lowest qualifying slot index; N means "none".
    always_comb begin
        ins_pos   = CW'(N);
        match_pos = CW'(N);
        match_hit = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!v_r[i] || better(cmd_price, price_r[i]))
                ins_pos = CW'(i);
            if (v_r[i] && (uid_r[i] == cmd_uid)) begin
                match_pos = CW'(i);
                match_hit = 1'b1;
            end
        end
    end

    assign dec_q = (qty_r[0] > cmd_qty) ? (qty_r[0] - cmd_qty) : '0;

    always_comb begin
        v_n         = v_r;
        uid_n       = uid_r;
        price_n     = price_r;
        qty_n       = qty_r;
        count_n     = count_r;
        rsp_ok_n    = 1'b0;
        rsp_uid_n   = '0;
        rsp_price_n = '0;
        rsp_qty_n   = '0;
        evict       = 1'b0;
        ev_uid      = '0;
        ev_price    = '0;
        ev_qty      = '0;
        rm_en       = 1'b0;
        rm_pos      = '0;
        if (acc) begin
            case (cmd_op)
                OP_INSTALL: begin
                    rsp_ok_n    = 1'b1;
                    rsp_uid_n   = cmd_uid;
                    rsp_price_n = cmd_price;
                    rsp_qty_n   = cmd_qty;
                    if (ins_pos == CW'(N)) begin
                        evict    = 1'b1;
                        ev_uid   = cmd_uid;
                        ev_price = cmd_price;
                        ev_qty   = cmd_qty;
                    end else begin
                        if (count_r == CW'(N)) begin
                            evict    = 1'b1;
                            ev_uid   = uid_r[N-1];
                            ev_price = price_r[N-1];
                            ev_qty   = qty_r[N-1];
                        end else begin
                            count_n = count_r + CW'(1);
                        end
                        for (int i = N - 1; i >= 1; i--) begin
                            if (CW'(i) > ins_pos) begin
                                v_n[i]     = v_r[i-1];
                                uid_n[i]   = uid_r[i-1];
                                price_n[i] = price_r[i-1];
                                qty_n[i]   = qty_r[i-1];
                            end
                        end
                        for (int i = 0; i < N; i++) begin
                            if (CW'(i) == ins_pos) begin
                                v_n[i]     = 1'b1;
                                uid_n[i]   = cmd_uid;
                                price_n[i] = cmd_price;
                                qty_n[i]   = cmd_qty;
                            end
                        end
                    end
                end
                OP_POP: begin
                    if (v_r[0]) begin
                        rsp_ok_n    = 1'b1;
                        rsp_uid_n   = uid_r[0];
                        rsp_price_n = price_r[0];
                        rsp_qty_n   = qty_r[0];
                        rm_en       = 1'b1;
                    end
                end
                OP_CANCEL: begin
                    rsp_uid_n = cmd_uid;
                    if (match_hit) begin
                        rsp_ok_n = 1'b1;
                        rm_en    = 1'b1;
                        rm_pos   = match_pos;
                        for (int i = 0; i < N; i++) begin
                            if (CW'(i) == match_pos) begin
                                rsp_uid_n   = uid_r[i];
                                rsp_price_n = price_r[i];
                                rsp_qty_n   = qty_r[i];
                            end
                        end
                    end
                end
                default: begin
                    if (v_r[0]) begin
                        rsp_ok_n    = 1'b1;
                        rsp_uid_n   = uid_r[0];
                        rsp_price_n = price_r[0];
                        rsp_qty_n   = dec_q;
                        if (dec_q == '0)
                            rm_en = 1'b1;
                        else
                            qty_n[0] = dec_q;
                    end
                end
            endcase
        end
        // Removal closes the gap and clears the vacated tail so empty slots read as zero.
        if (rm_en) begin
            for (int i = 0; i < N - 1; i++) begin
                if (CW'(i) >= rm_pos) begin
                    v_n[i]     = v_r[i+1];
                    uid_n[i]   = uid_r[i+1];
                    price_n[i] = price_r[i+1];
                    qty_n[i]   = qty_r[i+1];
                end
            end
            v_n[N-1]     = 1'b0;
            uid_n[N-1]   = '0;
            price_n[N-1] = '0;
            qty_n[N-1]   = '0;
            count_n      = count_r - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_r            <= '0;
            for (int i = 0; i < N; i++) begin
                uid_r[i]   <= '0;
                price_r[i] <= '0;
                qty_r[i]   <= '0;
            end
            count_r        <= '0;
            rsp_vld_r      <= 1'b0;
            rsp_ok_r       <= 1'b0;
            rsp_uid_r      <= '0;
            rsp_price_r    <= '0;
            rsp_qty_r      <= '0;
            reject_vld_r   <= 1'b0;
            reject_uid_r   <= '0;
            reject_price_r <= '0;
            reject_qty_r   <= '0;
        end else begin
            v_r         <= v_n;
            uid_r       <= uid_n;
            price_r     <= price_n;
            qty_r       <= qty_n;
            count_r     <= count_n;
            rsp_vld_r   <= acc;
            rsp_ok_r    <= rsp_ok_n;
            rsp_uid_r   <= rsp_uid_n;
            rsp_price_r <= rsp_price_n;
            rsp_qty_r   <= rsp_qty_n;
            if (evict) begin
                reject_vld_r   <= 1'b1;
                reject_uid_r   <= ev_uid;
                reject_price_r <= ev_price;
                reject_qty_r   <= ev_qty;
            end else if (reject_pop) begin
                reject_vld_r   <= 1'b0;
            end
        end
    end

`ifdef OB_SORTED_TABLE_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] c);
        return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_install_r     <= '0;
            stat_reject_r      <= '0;
            stat_cancel_r      <= '0;
            stat_cancel_miss_r <= '0;
        end else begin
            if (acc && cmd_op == OP_INSTALL)
                stat_install_r <= sat_inc(stat_install_r);
            if (evict)
                stat_reject_r <= sat_inc(stat_reject_r);
            if (acc && cmd_op == OP_CANCEL && match_hit)
                stat_cancel_r <= sat_inc(stat_cancel_r);
            if (acc && cmd_op == OP_CANCEL && !match_hit)
                stat_cancel_miss_r <= sat_inc(stat_cancel_miss_r);
        end
    end
`endif

endmodule

// File: tb/tb_ob_sorted_table.sv
// tb/tb_ob_sorted_table.sv - scoreboard bench for ob_sorted_table: ask (a) and bid (b) tables, N=4.
module tb_ob_sorted_table;

    localparam int N = 4;

    typedef struct {
        logic        ok;
        logic [31:0] uid;
        logic [15:0] price;
        logic [15:0] qty;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        a_cmd_vld = 0, a_cmd_rdy, a_reject_pop = 0;
    logic [1:0]  a_cmd_op = 0;
    logic [31:0] a_cmd_uid = 0;
    logic [15:0] a_cmd_price = 0, a_cmd_qty = 0;
    logic        a_rsp_vld, a_rsp_ok, a_head_vld, a_rej_vld;
    logic [31:0] a_rsp_uid, a_head_uid, a_rej_uid;
    logic [15:0] a_rsp_price, a_rsp_qty, a_head_price, a_head_qty, a_rej_price, a_rej_qty;
    logic [2:0]  a_count;

    logic        b_cmd_vld = 0, b_cmd_rdy, b_reject_pop = 0;
    logic [1:0]  b_cmd_op = 0;
    logic [31:0] b_cmd_uid = 0;
    logic [15:0] b_cmd_price = 0, b_cmd_qty = 0;
    logic        b_rsp_vld, b_rsp_ok, b_head_vld, b_rej_vld;
    logic [31:0] b_rsp_uid, b_head_uid, b_rej_uid;
    logic [15:0] b_rsp_price, b_rsp_qty, b_head_price, b_head_qty, b_rej_price, b_rej_qty;
    logic [2:0]  b_count;

    ob_sorted_table #(.N(N), .IS_ASK(1), .PRICE_W(16), .QTY_W(16), .UID_W(32)) dut_a (
        .clk(clk), .rst(rst), .cmd_vld(a_cmd_vld), .cmd_rdy(a_cmd_rdy), .cmd_op(a_cmd_op),
        .cmd_uid(a_cmd_uid), .cmd_price(a_cmd_price), .cmd_qty(a_cmd_qty),
        .rsp_vld_r(a_rsp_vld), .rsp_ok_r(a_rsp_ok), .rsp_uid_r(a_rsp_uid),
        .rsp_price_r(a_rsp_price), .rsp_qty_r(a_rsp_qty),
        .head_vld_r(a_head_vld), .head_uid_r(a_head_uid), .head_price_r(a_head_price),
        .head_qty_r(a_head_qty), .count_r(a_count),
        .reject_vld_r(a_rej_vld), .reject_uid_r(a_rej_uid), .reject_price_r(a_rej_price),
        .reject_qty_r(a_rej_qty), .reject_pop(a_reject_pop)
    );

    ob_sorted_table #(.N(N), .IS_ASK(0), .PRICE_W(16), .QTY_W(16), .UID_W(32)) dut_b (
        .clk(clk), .rst(rst), .cmd_vld(b_cmd_vld), .cmd_rdy(b_cmd_rdy), .cmd_op(b_cmd_op),
        .cmd_uid(b_cmd_uid), .cmd_price(b_cmd_price), .cmd_qty(b_cmd_qty),
        .rsp_vld_r(b_rsp_vld), .rsp_ok_r(b_rsp_ok), .rsp_uid_r(b_rsp_uid),
        .rsp_price_r(b_rsp_price), .rsp_qty_r(b_rsp_qty),
        .head_vld_r(b_head_vld), .head_uid_r(b_head_uid), .head_price_r(b_head_price),
        .head_qty_r(b_head_qty), .count_r(b_count),
        .reject_vld_r(b_rej_vld), .reject_uid_r(b_rej_uid), .reject_price_r(b_rej_price),
        .reject_qty_r(b_rej_qty), .reject_pop(b_reject_pop)
    );

    int   tests = 0;
    int   errors = 0;
    exp_t qa[$];
    exp_t qb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cmp_rsp(input string tag, input exp_t e, input logic ok, input logic [31:0] uid,
                           input logic [15:0] price, input logic [15:0] qty);
        chk({tag, ".rsp_ok"}, 64'(ok), 64'(e.ok));
        chk({tag, ".rsp_uid"}, 64'(uid), 64'(e.uid));
        chk({tag, ".rsp_price"}, 64'(price), 64'(e.price));
        chk({tag, ".rsp_qty"}, 64'(qty), 64'(e.qty));
    endtask

    // Response monitor: decoupled from stimulus, compares every pulse against the queue.
    always @(negedge clk) begin
        exp_t e;
        if (a_rsp_vld) begin
            if (qa.size() == 0) chk("a.unexpected_rsp", 64'd1, 64'd0);
            else begin e = qa.pop_front(); cmp_rsp("a", e, a_rsp_ok, a_rsp_uid, a_rsp_price, a_rsp_qty); end
        end
        if (b_rsp_vld) begin
            if (qb.size() == 0) chk("b.unexpected_rsp", 64'd1, 64'd0);
            else begin e = qb.pop_front(); cmp_rsp("b", e, b_rsp_ok, b_rsp_uid, b_rsp_price, b_rsp_qty); end
        end
    end

    task automatic issue(input bit sel, input logic [1:0] op, input logic [31:0] uid,
                         input logic [15:0] price, input logic [15:0] qty, input bit prj,
                         input logic e_ok, input logic [31:0] e_uid,
                         input logic [15:0] e_price, input logic [15:0] e_qty);
        exp_t e;
        e.ok = e_ok; e.uid = e_uid; e.price = e_price; e.qty = e_qty;
        @(negedge clk);
        if (!sel) begin
            a_cmd_op = op; a_cmd_uid = uid; a_cmd_price = price; a_cmd_qty = qty;
            a_reject_pop = prj; a_cmd_vld = 1'b1;
            #1 chk("a.cmd_rdy_before_issue", 64'(a_cmd_rdy), 64'd1);
            qa.push_back(e);
        end else begin
            b_cmd_op = op; b_cmd_uid = uid; b_cmd_price = price; b_cmd_qty = qty;
            b_reject_pop = prj; b_cmd_vld = 1'b1;
            #1 chk("b.cmd_rdy_before_issue", 64'(b_cmd_rdy), 64'd1);
            qb.push_back(e);
        end
        @(posedge clk);
        #1;
        a_cmd_vld = 1'b0; a_reject_pop = 1'b0;
        b_cmd_vld = 1'b0; b_reject_pop = 1'b0;
    endtask

    task automatic ins_a(input logic [31:0] uid, input logic [15:0] price, input logic [15:0] qty);
        issue(0, 2'd0, uid, price, qty, 0, 1'b1, uid, price, qty);
    endtask

    task automatic drain_reject_a();
        @(negedge clk);
        a_reject_pop = 1'b1;
        #1 chk("a.cmd_rdy_with_pop", 64'(a_cmd_rdy), 64'd1);
        @(posedge clk);
        #1 a_reject_pop = 1'b0;
        chk("a.reject_cleared", 64'(a_rej_vld), 64'd0);
    endtask

    task automatic head_a(input string tag, input logic hv, input logic [31:0] uid,
                          input logic [15:0] price, input logic [2:0] cnt);
        chk({tag, ".head_vld"}, 64'(a_head_vld), 64'(hv));
        chk({tag, ".head_uid"}, 64'(a_head_uid), 64'(uid));
        chk({tag, ".head_price"}, 64'(a_head_price), 64'(price));
        chk({tag, ".count"}, 64'(a_count), 64'(cnt));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        head_a("reset", 0, 0, 0, 0);
        chk("reset.rsp_vld", 64'(a_rsp_vld), 64'd0);
        chk("reset.reject_vld", 64'(a_rej_vld), 64'd0);
        chk("reset.b_count", 64'(b_count), 64'd0);

        // Ask ordering
        ins_a(1, 50, 5);
        ins_a(2, 30, 6);
        ins_a(3, 40, 7);
        head_a("ask3", 1, 2, 30, 3);
        issue(0, 2'd1, 0, 0, 0, 0, 1, 2, 30, 6);
        issue(0, 2'd1, 0, 0, 0, 0, 1, 3, 40, 7);
        issue(0, 2'd1, 0, 0, 0, 0, 1, 1, 50, 5);
        head_a("ask_empty", 0, 0, 0, 0);
        issue(0, 2'd1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Bid time priority
        issue(1, 2'd0, 7, 100, 1, 0, 1, 7, 100, 1);
        issue(1, 2'd0, 8, 100, 2, 0, 1, 8, 100, 2);
        chk("bid.head_uid", 64'(b_head_uid), 64'd7);
        issue(1, 2'd1, 0, 0, 0, 0, 1, 7, 100, 1);
        chk("bid.head_after_pop", 64'(b_head_uid), 64'd8);
        issue(1, 2'd0, 9, 120, 3, 0, 1, 9, 120, 3);
        chk("bid.head_better", 64'(b_head_uid), 64'd9);
        chk("bid.count", 64'(b_count), 64'd2);

        // Full table and overflow
        ins_a(10, 10, 1);
        ins_a(20, 20, 1);
        ins_a(30, 30, 1);
        ins_a(40, 40, 1);
        head_a("full", 1, 10, 10, 4);
        ins_a(9, 15, 2);
        chk("evict.reject_vld", 64'(a_rej_vld), 64'd1);
        chk("evict.reject_uid", 64'(a_rej_uid), 64'd40);
        chk("evict.reject_price", 64'(a_rej_price), 64'd40);
        chk("evict.cmd_rdy_low", 64'(a_cmd_rdy), 64'd0);
        head_a("evict", 1, 10, 10, 4);
        drain_reject_a();
        ins_a(99, 99, 3);
        chk("self_reject.uid", 64'(a_rej_uid), 64'd99);
        chk("self_reject.qty", 64'(a_rej_qty), 64'd3);
        head_a("self_reject", 1, 10, 10, 4);
        issue(0, 2'd0, 5, 5, 10, 1, 1, 5, 5, 10);
        chk("reload.reject_vld", 64'(a_rej_vld), 64'd1);
        chk("reload.reject_uid", 64'(a_rej_uid), 64'd30);
        head_a("reload", 1, 5, 5, 4);
        drain_reject_a();

        // Cancel
        issue(0, 2'd2, 9, 0, 0, 0, 1, 9, 15, 2);
        head_a("cancel_hit", 1, 5, 5, 3);
        issue(0, 2'd2, 32'hDEAD, 0, 0, 0, 0, 32'hDEAD, 0, 0);
        head_a("cancel_miss", 1, 5, 5, 3);

        // Quantity decrement
        issue(0, 2'd3, 0, 0, 4, 0, 1, 5, 5, 6);
        chk("dec.head_qty", 64'(a_head_qty), 64'd6);
        issue(0, 2'd3, 0, 0, 6, 0, 1, 5, 5, 0);
        head_a("dec_remove", 1, 10, 10, 2);
        issue(0, 2'd1, 0, 0, 0, 0, 1, 10, 10, 1);
        issue(0, 2'd1, 0, 0, 0, 0, 1, 20, 20, 1);
        issue(0, 2'd3, 0, 0, 1, 0, 0, 0, 0, 0);
        head_a("dec_empty", 0, 0, 0, 0);

        // Reset with full table, reject pending and a command in flight
        ins_a(32'h11, 1, 1);
        ins_a(32'h12, 2, 1);
        ins_a(32'h13, 3, 1);
        ins_a(32'h14, 4, 1);
        ins_a(32'h20, 0, 1);
        chk("pre_rst.reject_vld", 64'(a_rej_vld), 64'd1);
        @(negedge clk);
        a_cmd_op = 2'd0; a_cmd_uid = 32'h30; a_cmd_price = 0; a_cmd_qty = 1;
        a_cmd_vld = 1'b1; a_reject_pop = 1'b1; rst = 1'b1;
        @(posedge clk);
        #1 a_cmd_vld = 1'b0; a_reject_pop = 1'b0; rst = 1'b0;
        head_a("mid_rst", 0, 0, 0, 0);
        chk("mid_rst.reject_vld", 64'(a_rej_vld), 64'd0);
        chk("mid_rst.rsp_vld", 64'(a_rsp_vld), 64'd0);

        for (int k = 0; k < 20 && (qa.size() != 0 || qb.size() != 0); k++) @(posedge clk);
        repeat (2) @(posedge clk);
        chk("scoreboard_drained", 64'(qa.size() + qb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/ob_sorted_table.md
Name: ob_sorted_table

Overview:
- Price-time-priority sorted order table for one side of the order book, holding up to N resting orders; head is best price.
- Generalises the fixed install-only table: parametrised field widths and side.
- Adds head pop, head quantity decrement, cancel-by-UID, occupancy tracking and a single command/response handshake.
- Sits between the order-book control FSM (command source) and the matcher (head consumer); overflow spills into a reject register drained by the control FSM.

Parameters:
- N, 16, resting-order capacity (>=2).
- IS_ASK, 1, 1: ask side, smallest price at head; 0: bid side, largest price at head.
- PRICE_W, 16, price field width, unsigned.
- QTY_W, 16, quantity field width, unsigned.
- UID_W, 32, order identifier width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cmd_vld  in  1  command valid
- cmd_rdy  out  1  command accepted when cmd_vld & cmd_rdy
- cmd_op  in  2  0 INSTALL, 1 POP_HEAD, 2 CANCEL, 3 QTY_DEC
- cmd_uid  in  UID_W  order UID (INSTALL, CANCEL)
- cmd_price  in  PRICE_W  price (INSTALL)
- cmd_qty  in  QTY_W  quantity (INSTALL) or decrement amount (QTY_DEC)
- rsp_vld_r  out  1  one-cycle response pulse
- rsp_ok_r  out  1  command succeeded
- rsp_uid_r / rsp_price_r / rsp_qty_r  out  UID_W/PRICE_W/QTY_W  affected entry
- head_vld_r  out  1  table non-empty
- head_uid_r / head_price_r / head_qty_r  out  UID_W/PRICE_W/QTY_W  best entry
- count_r  out  $clog2(N+1)  occupied entries
- reject_vld_r  out  1  reject register holds an evicted entry
- reject_uid_r / reject_price_r / reject_qty_r  out  UID_W/PRICE_W/QTY_W  evicted entry
- reject_pop  in  1  consumer drains reject register

Behaviour:
- Storage: N slots, each valid/uid/price/qty; slot 0 is head; valid slots contiguous from 0.
- Reset:
  - all slots invalid; count_r=0; head_vld_r=0.
  - rsp_vld_r=0, reject_vld_r=0; all data outputs 0.
- Handshake:
  - cmd_rdy = ~reject_vld_r | reject_pop (combinational).
  - One command per cycle; result visible on registered outputs the cycle after acceptance.
  - rsp_vld_r pulses exactly once per accepted command.
- INSTALL:
  - Insert position = first slot i where slot invalid or new price strictly better than slot price (ask: <, bid: >). Equal prices insert behind existing entries (time priority).
  - Slots at and above i shift down by one. rsp_ok_r=1; rsp fields echo the command.
  - When count_r==N: the entry displaced from slot N-1 moves to the reject register, reject_vld_r=1, count_r unchanged.
  - If the new order is not better than slot N-1, the new order itself is rejected and the table is unchanged.
- POP_HEAD:
  - Removes slot 0 and shifts the rest up; rsp carries the popped entry, rsp_ok_r=1.
  - Empty table: rsp_ok_r=0, table unchanged.
- CANCEL:
  - Finds the first slot with matching valid UID, removes it and shifts the tail up; rsp carries the removed entry, ok=1.
  - No match: ok=0, rsp_uid_r=cmd_uid, table unchanged.
- QTY_DEC:
  - Head qty -= cmd_qty. A result of 0 (or cmd_qty >= qty, saturated) removes the head as in POP_HEAD.
  - rsp carries the post-decrement head entry with qty after saturation, ok=1. Empty table: ok=0.
- Reject register: cleared on reject_pop. Simultaneous reject_pop and an evicting INSTALL reloads it (reject_vld_r stays 1 with new data).
- head_* and count_r update in the same cycle as the table.
- rst mid-operation discards the in-flight command; no response is issued.

Optional Feature:
- Macro: OB_SORTED_TABLE_STATS_EN.
- Defined: adds outputs stat_install_r, stat_reject_r, stat_cancel_r, stat_cancel_miss_r (32 bits each). Each saturates at all-ones, resets to 0 and increments the cycle after the qualifying event.
- Undefined: no ports, counters or logic; behaviour otherwise identical.

Test Plan:
- Ask table, N=4: install prices 50, 30, 40 (uids 1, 2, 3) -> head uid 2 price 30; count 3; POP order 2, 3, 1.
- Bid table: install uid 7 @100, then uid 8 @100 -> head uid 7 (time priority); POP_HEAD -> rsp uid 7, new head uid 8.
- Ask N=4 full with 10, 20, 30, 40; install 15 uid 9 -> reject uid of 40, reject_vld_r=1, cmd_rdy=0 until reject_pop; install 99 -> 99 itself rejected.
- CANCEL of middle uid -> ok=1, remaining order preserved, count decrements; CANCEL of absent uid 0xDEAD -> ok=0, no change.
- QTY_DEC head qty 10 by 4 -> head qty 6; by 6 -> head removed, next entry promoted; on empty table -> ok=0.
- rst asserted mid-sequence with table full and reject pending -> next cycle count 0, head_vld_r=0, reject_vld_r=0, no rsp pulse.
